nco_quarter_wave: RTL and testbench

Parametrised numerically controlled oscillator (NCO). It combines a phase accumulator, a quarter-wave sine ROM with quadrant folding, and a 3-stage registered pipeline with a valid strobe. It sits between the control registers (tuning word, phase offset) and the DAC/PWM path. Its output is a signed sine sample stream at the rate set by the tuning word.

---
 rtl/nco_pkg.sv | 38 +++
 rtl/quarter_sine_rom.sv | 66 ++++++
 rtl/nco_quarter_wave.sv | 155 +++++++++++++++
 tb/tb_nco_quarter_wave.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and helpers for the quarter-wave NCO.
// The quadrant folding helper is common to every read port so the sine and
// cosine paths fold identically.
package nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  // mirror: read the table backwards (N-1-a); negate: flip the sign of the magnitude
  typedef struct packed {
    logic mirror;
    logic negate;
  } fold_t;

  // A quarter turn of the phase circle, 2**(pw-2); callers truncate to pw bits
  function automatic logic [63:0] quarter_phase(input int pw);
    return 64'd1 << (pw - 2);
  endfunction

  // Quadrants 1 and 3 run down the table, quadrants 2 and 3 are the negative half
  function automatic fold_t fold(input quadrant_t q);
    fold_t f;
    f.mirror = 1'b0;
    f.negate = 1'b0;
    unique case (q)
      Q0: begin f.mirror = 1'b0; f.negate = 1'b0; end
      Q1: begin f.mirror = 1'b1; f.negate = 1'b0; end
      Q2: begin f.mirror = 1'b0; f.negate = 1'b1; end
      Q3: begin f.mirror = 1'b1; f.negate = 1'b1; end
    endcase
    return f;
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude ROM with registered read.
// rom[k] = round((2**WIDTH-1) * sin((k+0.5)*pi/(2N))), N = 2**ADDR_BITS.
// The table is generated at elaboration with fixed-point Taylor arithmetic so
// the block carries no external image dependency; ROM_FILE names the matching
// hex image for flows that preload the array from a file.
// A second read port exists when NCO_QUADRATURE_EN is defined.
module quarter_sine_rom #(
  parameter int ADDR_BITS = 6,
  parameter int WIDTH     = 7,
  parameter     ROM_FILE  = "quarter_sine_rom.txt"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] addr_a,
  output logic [WIDTH-1:0]     data_a
`ifdef NCO_QUADRATURE_EN
  ,
  input  logic [ADDR_BITS-1:0] addr_b,
  output logic [WIDTH-1:0]     data_b
`endif
);

  localparam int     N     = 2 ** ADDR_BITS;
  localparam longint SCALE = 64'sd1 << 30;
  // pi scaled by 2**30
  localparam longint PI_FX = 64'sd3373259426;

  // Table entry k; Taylor series to x**17 keeps the error far below one LSB
  function automatic longint rom_entry(input int k);
    longint x, x2, term, acc, amp, val;
    x    = (longint'(2 * k + 1) * PI_FX) / longint'(4 * N);
    x2   = (x * x) / SCALE;
    term = x;
    acc  = x;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * x2) / SCALE) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    amp = (longint'(1) << WIDTH) - 1;
    val = (amp * acc + SCALE / 2) / SCALE;
    if (val > amp) val = amp;
    return val;
  endfunction

  logic [WIDTH-1:0] rom_table [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_table
    localparam logic [WIDTH-1:0] ENTRY = WIDTH'(rom_entry(gi));
    assign rom_table[gi] = ENTRY;
  end

  // Registered read, port A
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_a <= '0;
    else          data_a <= rom_table[addr_a];
  end

`ifdef NCO_QUADRATURE_EN
  // Registered read, port B
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_b <= '0;
    else          data_b <= rom_table[addr_b];
  end
`endif

endmodule

// File: rtl/nco_quarter_wave.sv
// Numerically controlled oscillator: phase accumulator, quarter-wave ROM
// with quadrant folding, and a 3-stage pipeline with a valid strobe.
// Optional macro NCO_QUADRATURE_EN adds a cosine output from a second ROM port.
module nco_quarter_wave
  import nco_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_BITS   = 6,
  parameter     ROM_FILE    = "quarter_sine_rom.txt"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    sync_clear,
  input  logic [PHASE_WIDTH-1:0]  ftw,
  input  logic [PHASE_WIDTH-1:0]  phase_offset,
  output logic signed [WIDTH-1:0] sine,
`ifdef NCO_QUADRATURE_EN
  output logic signed [WIDTH-1:0] cosine,
`endif
  output logic                    out_valid
);

  localparam int MAG_W = WIDTH - 1;
  localparam int PW    = PHASE_WIDTH;

  logic [PW-1:0]        phase_acc;
  logic [PW-1:0]        sample_phase;
  logic                 issue;

  quadrant_t            q1;
  logic [ADDR_BITS-1:0] a1;
  logic                 valid1;

  fold_t                fold_s;
  logic [ADDR_BITS-1:0] addr_s;
  logic [MAG_W-1:0]     m2;
  logic                 neg2;
  logic                 valid2;

  assign issue        = enable & ~sync_clear;
  assign sample_phase = phase_acc + phase_offset;

  // Accumulator: clear wins over advance; wraps modulo 2**PW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        phase_acc <= '0;
    else if (sync_clear) phase_acc <= '0;
    else if (enable)     phase_acc <= phase_acc + ftw;
  end

  // Stage 1: split the sample phase into quadrant and table address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1     <= Q0;
      a1     <= '0;
      valid1 <= 1'b0;
    end else begin
      q1     <= quadrant_t'(sample_phase[PW-1 -: 2]);
      a1     <= sample_phase[PW-3 -: ADDR_BITS];
      valid1 <= issue;
    end
  end

  // Fold the quadrant onto the quarter table
  always_comb begin
    fold_s = fold(q1);
    addr_s = fold_s.mirror ? ~a1 : a1;
  end

  // Stage 2 side band: sign and valid travel alongside the ROM read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      neg2   <= 1'b0;
      valid2 <= 1'b0;
    end else begin
      neg2   <= fold_s.negate;
      valid2 <= valid1;
    end
  end

`ifdef NCO_QUADRATURE_EN
  localparam logic [PW-1:0] QUARTER = PW'(quarter_phase(PW));

  logic [1:0]           cos_quad;
  quadrant_t            qc1;
  fold_t                fold_c;
  logic [ADDR_BITS-1:0] addr_c;
  logic [MAG_W-1:0]     mc2;
  logic                 negc2;

  // Adding a quarter turn only touches the quadrant bits; the address is shared
  assign cos_quad = sample_phase[PW-1 -: 2] + QUARTER[PW-1 -: 2];

  // Stage 1 quadrant for the cosine path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) qc1 <= Q0;
    else          qc1 <= quadrant_t'(cos_quad);
  end

  // Fold the cosine quadrant
  always_comb begin
    fold_c = fold(qc1);
    addr_c = fold_c.mirror ? ~a1 : a1;
  end

  // Stage 2 sign for the cosine path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) negc2 <= 1'b0;
    else          negc2 <= fold_c.negate;
  end

  quarter_sine_rom #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (MAG_W),
    .ROM_FILE  (ROM_FILE)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_a  (addr_s),
    .data_a  (m2),
    .addr_b  (addr_c),
    .data_b  (mc2)
  );

  // Stage 3 cosine: apply sign, hold between samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cosine <= '0;
    else if (valid2) cosine <= negc2 ? -$signed({1'b0, mc2}) : $signed({1'b0, mc2});
  end
`else
  quarter_sine_rom #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (MAG_W),
    .ROM_FILE  (ROM_FILE)
  ) u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr_a  (addr_s),
    .data_a  (m2)
  );
`endif

  // Stage 3 sine: apply sign, hold between samples, publish the strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sine      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid2;
      if (valid2) sine <= neg2 ? -$signed({1'b0, m2}) : $signed({1'b0, m2});
    end
  end

endmodule

// File: tb/tb_nco_quarter_wave.sv
// Self-checking bench for nco_quarter_wave (WIDTH=8, ADDR_BITS=6).
// The reference computes each sample straight from sin() of the quantised
// phase and delays it by the documented latency.
module tb_nco_quarter_wave;

  localparam int W     = 8;
  localparam int PW    = 32;
  localparam int AB    = 6;
  localparam int STEPS = 4 * (2 ** AB);
  localparam logic [PW-1:0] QTR = 32'h4000_0000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic                sync_clear = 1'b0;
  logic [PW-1:0]       ftw = '0;
  logic [PW-1:0]       phase_offset = '0;
  logic signed [W-1:0] sine;
  logic                out_valid;
`ifdef NCO_QUADRATURE_EN
  logic signed [W-1:0] cosine;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nco_quarter_wave #(
    .WIDTH       (W),
    .PHASE_WIDTH (PW),
    .ADDR_BITS   (AB),
    .ROM_FILE    ("quarter_sine_rom.txt")
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sync_clear   (sync_clear),
    .ftw          (ftw),
    .phase_offset (phase_offset),
    .sine         (sine),
`ifdef NCO_QUADRATURE_EN
    .cosine       (cosine),
`endif
    .out_valid    (out_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Sample for phase p: sin at the centre of its (4N)-th of a turn, magnitude rounded
  function automatic int ref_sample(input logic [PW-1:0] p);
    real ang, s, amp;
    int  u, m;
    u   = int'(p >> (PW - AB - 2));
    amp = real'((1 << (W - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(u) + 0.5) / real'(STEPS);
    s   = $sin(ang);
    m   = $rtoi(((s < 0.0) ? -s : s) * amp + 0.5);
    return (s < 0.0) ? -m : m;
  endfunction

  // Reference: phase bookkeeping plus a 3-cycle delay line of computed samples
  logic [PW-1:0] m_acc;
  logic          d1_v, d2_v, m_valid;
  int            d1_s, d2_s, m_sine, d1_c, d2_c, m_cos;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc <= '0; d1_v <= 1'b0; d2_v <= 1'b0; m_valid <= 1'b0;
      d1_s <= 0; d2_s <= 0; m_sine <= 0; d1_c <= 0; d2_c <= 0; m_cos <= 0;
    end else begin
      d1_v <= enable && !sync_clear;
      d1_s <= ref_sample(m_acc + phase_offset);
      d1_c <= ref_sample(m_acc + phase_offset + QTR);
      if (sync_clear)  m_acc <= '0;
      else if (enable) m_acc <= m_acc + ftw;
      d2_v <= d1_v; d2_s <= d1_s; d2_c <= d1_c;
      m_valid <= d2_v;
      if (d2_v) begin
        m_sine <= d2_s;
        m_cos  <= d2_c;
      end
    end
  end

  // Every-cycle comparison against the reference while out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("sine", int'(sine), m_sine);
`ifdef NCO_QUADRATURE_EN
      check("cosine", int'(cosine), m_cos);
`endif
      if (out_valid) $display("sample t=%0t sine=%0d ref=%0d", $time, sine, m_sine);
    end
  end

  int smp [512];
  int v_obs [12];
  int s_obs [12];

  initial begin
    int n, bad, mx, mn;
    int exp_v [12];
    int exp_s [12];
    logic [PW-1:0] offs [3];
    int            offs_exp [3];
    offs[0] = 32'h4000_0000; offs_exp[0] = 127;
    offs[1] = 32'h8000_0000; offs_exp[1] = -2;
    offs[2] = 32'hC000_0000; offs_exp[2] = -127;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sine", int'(sine), 0);
    check("rst_valid", int'(out_valid), 0);

    // Hand-computed pins on the reference itself
    check("pin_q0", ref_sample(32'h0000_0000), 2);
    check("pin_q1", ref_sample(32'h4000_0000), 127);
    check("pin_q2", ref_sample(32'h8000_0000), -2);
    check("pin_q3", ref_sample(32'hC000_0000), -127);
    check("pin_u4", ref_sample(32'h0400_0000), 14);
    check("pin_u8", ref_sample(32'h0800_0000), 26);

    // First sample latency with ftw=0, offset 0
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk); check("lat_c1", int'(out_valid), 0);
    @(negedge clk); check("lat_c2", int'(out_valid), 0);
    @(negedge clk); check("lat_c3", int'(out_valid), 1);
    check("dc_q0", int'(sine), 2);
`ifdef NCO_QUADRATURE_EN
    check("dc_cos_q0", int'(cosine), 127);
`endif

    // Constant output per quadrant offset
    for (int i = 0; i < 3; i++) begin
      phase_offset = offs[i];
      repeat (4) @(negedge clk);
      check("dc_offset", int'(sine), offs_exp[i]);
    end

    // 256-sample period: odd symmetry, full-scale peaks, exact repetition
    phase_offset = '0;
    ftw = 32'h0100_0000;
    repeat (4) @(negedge clk);
    n = 0;
    for (int c = 0; c < 600 && n < 512; c++) begin
      @(negedge clk);
      if (out_valid) begin
        smp[n] = int'(sine);
        n++;
      end
    end
    check("period_count", n, 512);
    if (n == 512) begin
      bad = 0; mx = -1000; mn = 1000;
      for (int i = 0; i < 128; i++) if (smp[i + 128] != -smp[i]) bad++;
      check("odd_symmetry", bad, 0);
      for (int i = 0; i < 256; i++) begin
        if (smp[i] > mx) mx = smp[i];
        if (smp[i] < mn) mn = smp[i];
      end
      check("peak_pos", mx, 127);
      check("peak_neg", mn, -127);
      bad = 0;
      for (int i = 0; i < 256; i++) if (smp[i + 256] != smp[i]) bad++;
      check("period_repeat", bad, 0);
    end

    // sync_clear with enable, then enable toggling 1,0,1,0,1 with ftw=0x0400_0000
    ftw = 32'h0400_0000;
    sync_clear = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      v_obs[k] = int'(out_valid);
      s_obs[k] = int'(sine);
      sync_clear = 1'b0;
      enable = (k < 5) && (k % 2 == 0);
    end
    exp_v = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    exp_s = '{0, 0, 0, 2, 2, 14, 14, 26, 26, 26, 26, 26};
    for (int k = 2; k < 12; k++) begin
      check("toggle_valid", v_obs[k], exp_v[k]);
      if (k >= 3) check("toggle_sine", s_obs[k], exp_s[k]);
    end

    // Asynchronous reset mid-stream, then restart from phase 0
    enable = 1'b1;
    ftw = 32'h0123_4567;
    phase_offset = 32'h1357_9BDF;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sine", int'(sine), 0);
    check("arst_valid", int'(out_valid), 0);
    @(negedge clk);
    check("arst_hold_valid", int'(out_valid), 0);
    phase_offset = '0;
    reset_n = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge clk);
      if (out_valid) n = 1;
    end
    check("arst_restart_seen", n, 1);
    check("arst_first_sample", int'(sine), 2);
`ifdef NCO_QUADRATURE_EN
    check("arst_first_cos", int'(cosine), 127);
`endif

    // Randomised stream against the reference
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 64 == 0) ftw = $urandom;
      if (c % 50 == 7) phase_offset = $urandom;
      enable     = ($urandom_range(0, 3) != 0);
      sync_clear = ($urandom_range(0, 31) == 0);
    end
    enable = 1'b0;
    sync_clear = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
